serial_deserializer: RTL and testbench
======================================

// Module: serial_deserializer
// PURPOSE
//  Downstream stage of the shift register: consumes its serial bit stream and
//  reassembles WIDTH-bit words. A completed word is held in an output buffer
//  and offered to the next stage on a valid/ready handshake.
//  A sticky overrun flag records words dropped because of back-pressure.
// PARAMETERS
//  WIDTH      6  word width in bits; must be >= 2
//  MSB_FIRST  1  1: first received bit lands in wordOut[WIDTH-1]; 0: in wordOut[0]
// PORTS
//  clk          input   1              rising-edge clock
//  reset        input   1              asynchronous, active-low reset
//  serialIn     input   1              serial data bit (the shift register's dataOut)
//  serialValid  input   1              serialIn is valid and sampled this cycle
//  clear        input   1              sync frame restart; also clears overrun
//  wordOut      output  WIDTH          assembled word (output buffer)
//  wordValid    output  1              wordOut holds an unconsumed word
//  wordReady    input   1              consumer accepts wordOut this cycle
//  overrun      output  1              sticky: a completed word was dropped
//  bitCount     output  clog2(WIDTH)   bits received in the current frame
// BEHAVIOUR
//  Reset (reset=0, async): shift reg=0, bitCount=0, wordOut=0, wordValid=0, overrun=0.
//  Bit capture: each edge with serialValid=1 and clear=0 shifts serialIn into the
//   shift register and increments bitCount; serialValid=0 holds all state.
//  Frame end: edge capturing bit WIDTH (bitCount==WIDTH-1) wraps bitCount to 0 and
//   completes the word (shift reg + final bit); bitCount never exceeds WIDTH-1.
//  Latency: completed word visible on wordOut, wordValid=1 the cycle after the last bit edge.
//  Output buffer FSM, states EMPTY (wordValid=0) / FULL (wordValid=1):
//   EMPTY + word completes                -> FULL, load wordOut
//   FULL  + wordReady, no completion      -> EMPTY (wordOut keeps last value)
//   FULL  + wordReady + completion        -> FULL, load new word (no bubble)
//   FULL  + !wordReady + completion       -> FULL, old word kept, new word
//                                            dropped, overrun<=1
//   wordReady while EMPTY is ignored.
//  wordOut/wordValid stable while FULL and wordReady=0.
//  clear=1: bitCount<=0, shift reg<=0, overrun<=0; output buffer unaffected;
//   clear has priority over serialValid (bit in that cycle discarded, no completion).
//  Reset mid-frame or with buffer FULL: partial word and buffered word lost,
//   all outputs to reset values immediately.
//  MSB_FIRST=1: shift left, serialIn enters bit 0; MSB_FIRST=0: shift right,
//   serialIn enters bit WIDTH-1.
// STRUCTURE
//  Shared package: buffer state enum {EMPTY, FULL}; CNT_W = clog2(WIDTH) helper.
//  One natural sub-module: deser_out_buffer (one-entry valid/ready holding
//   register incl. overrun logic); shift register and bit counter stay in top.
// TESTING
//  1 Reset held 2 cycles, then released -> wordOut=0, wordValid=0, overrun=0, bitCount=0.
//  2 MSB_FIRST=1, serialValid=1, bits 1,0,0,1,0,0 on 6 edges, wordReady=0
//    -> next cycle wordOut=6'd36, wordValid=1, bitCount=0.
//  3 Same bits with serialValid=0 inserted between bits 3 and 4 for 3 cycles
//    -> bitCount holds at 3, final wordOut=6'd36.
//  4 Word 36 buffered, wordReady=0, send 6 bits of 6'd21 -> wordOut stays 36,
//    overrun=1; assert clear -> overrun=0, wordValid=1, wordOut=36.
//  5 Word 36 buffered, wordReady=1 on edge of last bit of 6'd45 -> wordOut=45,
//    wordValid remains 1, overrun=0.
//  6 After 3 bits, clear=1 with serialValid=1 -> bitCount=0, bit discarded;
//    then 6 bits of 6'd63 -> wordOut=63. Drop reset mid-frame -> all outputs 0 at once.
//  Plus 5000 random serialValid/serialIn/wordReady cycles against a reference model.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// serial_deserializer_pkg: shared types and helpers for the serial deserializer.
package serial_deserializer_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/deser_out_buffer.sv
// deser_out_buffer: one-entry valid/ready holding register with sticky overrun.
module deser_out_buffer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_overrun
);

    buf_state_t       r_state;
    buf_state_t       w_next;
    logic             w_take;
    logic             w_drop;
    logic [WIDTH-1:0] r_word;
    logic             r_overrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= EMPTY;
        else        r_state <= w_next;
    end

    // A completion is taken when the slot is free or being drained this cycle.
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_drop = 1'b0;
        w_take = i_load && (r_state == EMPTY || i_ready);
        w_drop = i_load && r_state == FULL && !i_ready;
        w_next = i_load ? FULL : ((r_state == FULL && i_ready) ? EMPTY : r_state);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_take) r_word <= i_word;
            if (i_clear)     r_overrun <= 1'b0;
            else if (w_drop) r_overrun <= 1'b1;
        end
    end

    assign o_word    = r_word;
    assign o_valid   = (r_state == FULL);
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: reassembles WIDTH-bit words from a serial bit stream and
// offers them through a one-entry valid/ready output buffer.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serialIn,
    input  logic                      serialValid,
    input  logic                      clear,
    output logic [WIDTH-1:0]          wordOut,
    output logic                      wordValid,
    input  logic                      wordReady,
    output logic                      overrun,
    output logic [cnt_w(WIDTH)-1:0]   bitCount
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_capture;
    logic             w_last;

    // The completed word is the shift register plus the bit arriving this edge.
    assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], serialIn}
                                    : {serialIn, r_shift[WIDTH-1:1]};
    assign w_capture    = serialValid && !clear;
    assign w_last       = w_capture && r_count == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_capture) begin
            r_shift <= w_last ? '0 : w_shift_next;
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

    deser_out_buffer #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_last),
        .i_word    (w_shift_next),
        .i_ready   (wordReady),
        .i_clear   (clear),
        .o_word    (wordOut),
        .o_valid   (wordValid),
        .o_overrun (overrun)
    );

    assign bitCount = r_count;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed scenarios plus randomized run against a queue-based model.
module tb_serial_deserializer;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         serialIn = 1'b0;
    logic         serialValid = 1'b0;
    logic         clear = 1'b0;
    logic         wordReady = 1'b0;
    logic [W-1:0] wordOut;
    logic         wordValid;
    logic         overrun;
    logic [2:0]   bitCount;

    int n_cmp = 0;
    int n_err = 0;

    bit m_bits[$];
    int m_word = 0;
    bit m_valid = 0;
    bit m_ovr = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .serialIn    (serialIn),
        .serialValid (serialValid),
        .clear       (clear),
        .wordOut     (wordOut),
        .wordValid   (wordValid),
        .wordReady   (wordReady),
        .overrun     (overrun),
        .bitCount    (bitCount)
    );

    task automatic model_reset();
        m_bits.delete();
        m_word  = 0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    // Behavioural view: collect bits in a list, value them MSB-first once W arrive.
    task automatic model_edge(input bit sv, input bit si, input bit rdy, input bit clr);
        bit done = 0;
        int w = 0;
        if (clr) begin
            m_bits.delete();
            m_ovr = 0;
        end else if (sv) begin
            m_bits.push_back(si);
            if (m_bits.size() == W) begin
                foreach (m_bits[k]) w = w * 2 + int'(m_bits[k]);
                m_bits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word  = w;
                m_valid = 1;
            end else m_ovr = 1;
        end else if (rdy) m_valid = 0;
    endtask

    task automatic step(input bit sv, input bit si, input bit rdy, input bit clr);
        serialValid = sv;
        serialIn    = si;
        wordReady   = rdy;
        clear       = clr;
        @(posedge clk);
        model_edge(sv, si, rdy, clr);
        #1;
        serialValid = 0;
        wordReady   = 0;
        clear       = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy_last);
        for (int i = W - 1; i >= 0; i--) step(1, w[i], (i == 0) ? rdy_last : 1'b0, 0);
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (wordOut !== 6'd0) begin n_err++; $display("FAIL reset_word got=%0d exp=0", wordOut); end
        n_cmp++; if (wordValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", wordValid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        n_cmp++; if (bitCount !== 3'd0) begin n_err++; $display("FAIL reset_bitcount got=%0d exp=0", bitCount); end
    endtask

    task automatic test_msb_word();
        send_word(6'b100100, 0);
        n_cmp++; if (wordOut !== 6'd36) begin n_err++; $display("FAIL msb_word got=%0d exp=36", wordOut); end
        n_cmp++; if (wordValid !== 1'b1) begin n_err++; $display("FAIL msb_valid got=%b exp=1", wordValid); end
        n_cmp++; if (bitCount !== 3'd0) begin n_err++; $display("FAIL msb_bitcount got=%0d exp=0", bitCount); end
    endtask

    task automatic test_gaps();
        logic [W-1:0] w = 6'd36;
        step(0, 0, 1, 0);
        n_cmp++; if (wordValid !== 1'b0) begin n_err++; $display("FAIL gap_drain got=%b exp=0", wordValid); end
        for (int i = W - 1; i >= 3; i--) step(1, w[i], 0, 0);
        for (int c = 0; c < 3; c++) begin
            step(0, 1, 0, 0);
            n_cmp++; if (bitCount !== 3'd3) begin n_err++; $display("FAIL gap_hold got=%0d exp=3", bitCount); end
        end
        for (int i = 2; i >= 0; i--) step(1, w[i], 0, 0);
        n_cmp++; if (wordOut !== 6'd36 || wordValid !== 1'b1) begin n_err++; $display("FAIL gap_word got=%0d/%b exp=36/1", wordOut, wordValid); end
    endtask

    task automatic test_overrun();
        send_word(6'd21, 0);
        n_cmp++; if (wordOut !== 6'd36) begin n_err++; $display("FAIL ovr_keep got=%0d exp=36", wordOut); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        step(0, 0, 0, 1);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        n_cmp++; if (wordValid !== 1'b1 || wordOut !== 6'd36) begin n_err++; $display("FAIL ovr_buf got=%0d/%b exp=36/1", wordOut, wordValid); end
    endtask

    task automatic test_back_to_back();
        send_word(6'd45, 1);
        n_cmp++; if (wordOut !== 6'd45) begin n_err++; $display("FAIL b2b_word got=%0d exp=45", wordOut); end
        n_cmp++; if (wordValid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%b exp=1", wordValid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_clear_and_reset();
        step(0, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        n_cmp++; if (bitCount !== 3'd0) begin n_err++; $display("FAIL clr_bitcount got=%0d exp=0", bitCount); end
        n_cmp++; if (wordValid !== 1'b0) begin n_err++; $display("FAIL clr_nocomplete got=%b exp=0", wordValid); end
        send_word(6'd63, 0);
        n_cmp++; if (wordOut !== 6'd63 || wordValid !== 1'b1) begin n_err++; $display("FAIL clr_word got=%0d/%b exp=63/1", wordOut, wordValid); end
        repeat (3) step(1, 0, 0, 0);
        @(negedge clk);
        reset = 0;
        #1;
        n_cmp++; if (wordOut !== 6'd0 || wordValid !== 1'b0 || overrun !== 1'b0 || bitCount !== 3'd0)
            begin n_err++; $display("FAIL async_reset got=%0d/%b/%b/%0d exp=0/0/0/0", wordOut, wordValid, overrun, bitCount); end
        @(posedge clk);
        #1;
        reset = 1;
        model_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 5000; c++) begin
            step($urandom_range(99) < 70, $urandom_range(1), $urandom_range(1), $urandom_range(99) < 3);
            n_cmp++;
            if (wordOut !== W'(m_word) || wordValid !== m_valid || overrun !== m_ovr || bitCount !== 3'(m_bits.size())) begin
                n_err++;
                if (n_err < 20)
                    $display("FAIL rand_cycle%0d got=%0d/%b/%b/%0d exp=%0d/%b/%b/%0d", c, wordOut, wordValid, overrun,
                             bitCount, m_word, m_valid, m_ovr, m_bits.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_word();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_clear_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
